pll_lock_ctrl: RTL and testbench

- Reset/lock sequencer for one PLL instance: drives the PLL reset, waits for and qualifies its lock output, retries on timeout, and produces a clean downstream reset and ready flag.
- Sits beside the PLL wrapper in the clock subsystem (pwm/zynqclk) and runs on the PLL reference clock.
- Gates the PWM logic on the PLL output clock until lock is stable, and re-sequences the PLL after loss of lock.

---
 rtl/pll_lock_ctrl.sv | 161 ++++++++++++++++
 tb/tb_pll_lock_ctrl.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_ctrl.sv
`default_nettype none
// ============================================================================
// pll_lock_ctrl : PLL reset/lock sequencer with retry, fault and ready/sys_rst.
// Optional lock-loss event counter: define PLLCTL_LOSS_CNT_EN.
// Revision: 1.0
// ============================================================================
module pll_lock_ctrl #(
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_STABLE  = 1024,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int MAX_RETRY    = 3
) (
  input  logic        refclk,
  input  logic        rst,
  input  logic        pll_locked,
  input  logic        restart,
  output logic        pll_rst,
  output logic        sys_rst,
  output logic        ready,
  output logic        fault,
  output logic [3:0]  retry_cnt,
  output logic        lock_lost,
  output logic [15:0] lock_loss_cnt
);

  localparam int c_MAX_A   = (RST_CYCLES > LOCK_STABLE) ? RST_CYCLES : LOCK_STABLE;
  localparam int c_CNT_MAX = (c_MAX_A > LOCK_TIMEOUT) ? c_MAX_A : LOCK_TIMEOUT;
  localparam int c_CNT_W   = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;

  localparam logic [c_CNT_W-1:0] c_RST_LAST = c_CNT_W'(RST_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_STB_LAST = c_CNT_W'(LOCK_STABLE - 1);
  localparam logic [c_CNT_W-1:0] c_TMO_LAST = c_CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
  localparam logic [3:0]         c_RETRY_MAX = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAULT     = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_CNT_W-1:0] r_cnt;
  logic [c_CNT_W-1:0] w_cnt_nxt;
  logic [3:0]         r_retry;
  logic [3:0]         w_retry_nxt;
  logic               r_lock_meta;
  logic               r_lock_s;
  logic               r_pll_rst;
  logic               r_sys_rst;
  logic               r_ready;
  logic               r_fault;
  logic               r_lock_lost;
  logic               w_loss_evt;

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      r_lock_meta <= 1'b0;
      r_lock_s    <= 1'b0;
    end else begin
      r_lock_meta <= pll_locked;
      r_lock_s    <= r_lock_meta;
    end
  end

  // Outputs are decoded from the next state and registered with it, so they
  // switch on the same edge as the state and never glitch.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      r_state     <= S_RESET_PLL;
      r_cnt       <= '0;
      r_retry     <= 4'd0;
      r_pll_rst   <= 1'b1;
      r_sys_rst   <= 1'b1;
      r_ready     <= 1'b0;
      r_fault     <= 1'b0;
      r_lock_lost <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_retry     <= w_retry_nxt;
      r_pll_rst   <= (w_state_nxt == S_RESET_PLL) || (w_state_nxt == S_FAULT);
      r_sys_rst   <= (w_state_nxt != S_RUN);
      r_ready     <= (w_state_nxt == S_RUN);
      r_fault     <= (w_state_nxt == S_FAULT);
      r_lock_lost <= r_lock_lost | w_loss_evt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    w_retry_nxt = r_retry;
    w_loss_evt  = 1'b0;
    case (r_state)
      S_RESET_PLL: begin
        if (r_cnt == c_RST_LAST) w_state_nxt = S_WAIT_LOCK;
        else                     w_cnt_nxt   = r_cnt + c_CNT_ONE;
      end
      S_WAIT_LOCK: begin
        if (r_lock_s) begin
          w_state_nxt = S_STABLE;
        end else if (r_cnt == c_TMO_LAST) begin
          if (r_retry == c_RETRY_MAX) begin
            w_state_nxt = S_FAULT;
          end else begin
            w_retry_nxt = r_retry + 4'd1;
            w_state_nxt = S_RESET_PLL;
          end
        end else begin
          w_cnt_nxt = r_cnt + c_CNT_ONE;
        end
      end
      S_STABLE: begin
        // A dropout restarts the timeout window without counting as a retry.
        if (!r_lock_s)                w_state_nxt = S_WAIT_LOCK;
        else if (r_cnt == c_STB_LAST) w_state_nxt = S_RUN;
        else                          w_cnt_nxt   = r_cnt + c_CNT_ONE;
      end
      S_RUN: begin
        if (!r_lock_s) begin
          w_loss_evt  = 1'b1;
          w_retry_nxt = 4'd0;
          w_state_nxt = S_RESET_PLL;
        end
      end
      S_FAULT: begin
        if (restart) begin
          w_retry_nxt = 4'd0;
          w_state_nxt = S_RESET_PLL;
        end
      end
      default: w_state_nxt = S_RESET_PLL;
    endcase
  end

`ifdef PLLCTL_LOSS_CNT_EN
  logic [15:0] r_loss_cnt;

  always_ff @(posedge refclk or posedge rst) begin
    if (rst)                                    r_loss_cnt <= 16'd0;
    else if (w_loss_evt && r_loss_cnt != 16'hFFFF) r_loss_cnt <= r_loss_cnt + 16'd1;
  end

  assign lock_loss_cnt = r_loss_cnt;
`else
  assign lock_loss_cnt = 16'd0;
`endif

  assign pll_rst   = r_pll_rst;
  assign sys_rst   = r_sys_rst;
  assign ready     = r_ready;
  assign fault     = r_fault;
  assign retry_cnt = r_retry;
  assign lock_lost = r_lock_lost;

endmodule
`default_nettype wire

// File: tb/tb_pll_lock_ctrl.sv
`default_nettype none
// ============================================================================
// tb_pll_lock_ctrl : directed self-checking bench for pll_lock_ctrl.
// Revision: 1.0
// ============================================================================
module tb_pll_lock_ctrl;

  localparam int RST_CYCLES   = 4;
  localparam int LOCK_STABLE  = 8;
  localparam int LOCK_TIMEOUT = 32;
  localparam int MAX_RETRY    = 2;
`ifdef PLLCTL_LOSS_CNT_EN
  localparam logic [15:0] c_EXP_LOSS = 16'd1;
`else
  localparam logic [15:0] c_EXP_LOSS = 16'd0;
`endif

  logic        refclk;
  logic        rst;
  logic        pll_locked;
  logic        restart;
  logic        pll_rst;
  logic        sys_rst;
  logic        ready;
  logic        fault;
  logic [3:0]  retry_cnt;
  logic        lock_lost;
  logic [15:0] lock_loss_cnt;

  int checks   = 0;
  int failures = 0;

  pll_lock_ctrl #(
    .RST_CYCLES  (RST_CYCLES),
    .LOCK_STABLE (LOCK_STABLE),
    .LOCK_TIMEOUT(LOCK_TIMEOUT),
    .MAX_RETRY   (MAX_RETRY)
  ) dut (
    .refclk       (refclk),
    .rst          (rst),
    .pll_locked   (pll_locked),
    .restart      (restart),
    .pll_rst      (pll_rst),
    .sys_rst      (sys_rst),
    .ready        (ready),
    .fault        (fault),
    .retry_cnt    (retry_cnt),
    .lock_lost    (lock_lost),
    .lock_loss_cnt(lock_loss_cnt)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  // Leaves the bench 1 time unit after the edge on which rst was released.
  task automatic apply_reset();
    rst        = 1'b1;
    pll_locked = 1'b0;
    restart    = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    pll_locked = 1'b0;
    restart    = 1'b0;
    tick();
    tick();
    checks++;
    if ({pll_rst, sys_rst, ready, fault, lock_lost} !== 5'b11000) begin
      failures++;
      $display("FAIL reset_flags: got %b expected 11000", {pll_rst, sys_rst, ready, fault, lock_lost});
    end
    checks++;
    if (retry_cnt !== 4'd0) begin
      failures++;
      $display("FAIL reset_retry: got %0d expected 0", retry_cnt);
    end
    checks++;
    if (lock_loss_cnt !== 16'd0) begin
      failures++;
      $display("FAIL reset_loss_cnt: got %0d expected 0", lock_loss_cnt);
    end
  endtask

  task automatic test_bringup();
    int   n;
    logic seen;
    apply_reset();
    n = 0;
    while (pll_rst === 1'b1 && n < 50) begin tick(); n++; end
    checks++;
    if (n != RST_CYCLES) begin
      failures++;
      $display("FAIL bringup_pll_rst_len: got %0d expected %0d", n, RST_CYCLES);
    end
    repeat (6) tick();
    pll_locked = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin tick(); seen |= ready; end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL bringup_ready_early: got %b expected 0", seen);
    end
    tick();
    checks++;
    if ({ready, sys_rst, pll_rst, fault} !== 4'b1000) begin
      failures++;
      $display("FAIL bringup_run: got %b expected 1000", {ready, sys_rst, pll_rst, fault});
    end
    checks++;
    if (retry_cnt !== 4'd0) begin
      failures++;
      $display("FAIL bringup_retry: got %0d expected 0", retry_cnt);
    end
  endtask

  task automatic test_chatter();
    logic seen;
    apply_reset();
    repeat (4) tick();
    pll_locked = 1'b1;
    seen = 1'b0;
    repeat (5) begin tick(); seen |= ready; end
    pll_locked = 1'b0;
    tick();
    seen |= ready;
    pll_locked = 1'b1;
    repeat (10) begin tick(); seen |= ready; end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL chatter_ready_early: got %b expected 0", seen);
    end
    tick();
    checks++;
    if ({ready, sys_rst} !== 2'b10) begin
      failures++;
      $display("FAIL chatter_run: got %b expected 10", {ready, sys_rst});
    end
    checks++;
    if (retry_cnt !== 4'd0) begin
      failures++;
      $display("FAIL chatter_retry: got %0d expected 0", retry_cnt);
    end
  endtask

  task automatic test_timeout();
    int         rises;
    int         n;
    logic       prev;
    logic       chk;
    logic [6:0] exp;
    apply_reset();
    prev  = pll_rst;
    rises = 0;
    for (int e = 1; e <= 120; e++) begin
      tick();
      if (pll_rst && !prev && !fault) rises++;
      prev = pll_rst;
      chk  = 1'b1;
      exp  = 7'd0;
      // {pll_rst, sys_rst, fault, retry_cnt}
      case (e)
        3:       exp = {3'b110, 4'd0};
        4:       exp = {3'b010, 4'd0};
        35:      exp = {3'b010, 4'd0};
        36:      exp = {3'b110, 4'd1};
        40:      exp = {3'b010, 4'd1};
        72:      exp = {3'b110, 4'd2};
        76:      exp = {3'b010, 4'd2};
        107:     exp = {3'b010, 4'd2};
        108:     exp = {3'b111, 4'd2};
        120:     exp = {3'b111, 4'd2};
        default: chk = 1'b0;
      endcase
      if (chk) begin
        checks++;
        if ({pll_rst, sys_rst, fault, retry_cnt} !== exp) begin
          failures++;
          $display("FAIL timeout_edge%0d: got %b expected %b", e, {pll_rst, sys_rst, fault, retry_cnt}, exp);
        end
      end
    end
    checks++;
    if (rises != 2) begin
      failures++;
      $display("FAIL timeout_retry_pulses: got %0d expected 2", rises);
    end
    restart = 1'b1;
    tick();
    restart = 1'b0;
    checks++;
    if ({pll_rst, sys_rst, fault, retry_cnt} !== {3'b110, 4'd0}) begin
      failures++;
      $display("FAIL restart_exit: got %b expected 1100000", {pll_rst, sys_rst, fault, retry_cnt});
    end
    n = 0;
    while (pll_rst === 1'b1 && n < 50) begin tick(); n++; end
    checks++;
    if (n != RST_CYCLES) begin
      failures++;
      $display("FAIL restart_pll_rst_len: got %0d expected %0d", n, RST_CYCLES);
    end
  endtask

  task automatic test_restart_ignored();
    apply_reset();
    repeat (5) tick();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    checks++;
    if ({pll_rst, sys_rst, ready, fault, retry_cnt} !== {4'b0100, 4'd0}) begin
      failures++;
      $display("FAIL restart_wait_outputs: got %b expected 01000000", {pll_rst, sys_rst, ready, fault, retry_cnt});
    end
    repeat (29) tick();
    checks++;
    if ({pll_rst, retry_cnt} !== {1'b0, 4'd0}) begin
      failures++;
      $display("FAIL restart_wait_timer_e35: got %b expected 00000", {pll_rst, retry_cnt});
    end
    tick();
    checks++;
    if ({pll_rst, retry_cnt} !== {1'b1, 4'd1}) begin
      failures++;
      $display("FAIL restart_wait_timer_e36: got %b expected 10001", {pll_rst, retry_cnt});
    end
    apply_reset();
    repeat (4) tick();
    pll_locked = 1'b1;
    repeat (11) tick();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    tick();
    checks++;
    if ({pll_rst, sys_rst, ready, fault, retry_cnt} !== {4'b0010, 4'd0}) begin
      failures++;
      $display("FAIL restart_run_outputs: got %b expected 00100000", {pll_rst, sys_rst, ready, fault, retry_cnt});
    end
  endtask

  task automatic test_loss_in_run();
    int n;
    apply_reset();
    repeat (4) tick();
    pll_locked = 1'b1;
    repeat (11) tick();
    checks++;
    if ({ready, lock_lost} !== 2'b10) begin
      failures++;
      $display("FAIL loss_pre_run: got %b expected 10", {ready, lock_lost});
    end
    repeat (3) tick();
    pll_locked = 1'b0;
    tick();
    tick();
    checks++;
    if (ready !== 1'b1) begin
      failures++;
      $display("FAIL loss_sync_latency: got %b expected 1", ready);
    end
    tick();
    checks++;
    if ({pll_rst, sys_rst, ready, lock_lost} !== 4'b1101) begin
      failures++;
      $display("FAIL loss_exit_run: got %b expected 1101", {pll_rst, sys_rst, ready, lock_lost});
    end
    checks++;
    if (retry_cnt !== 4'd0) begin
      failures++;
      $display("FAIL loss_retry: got %0d expected 0", retry_cnt);
    end
    pll_locked = 1'b1;
    n = 0;
    while (ready !== 1'b1 && n < 200) begin tick(); n++; end
    checks++;
    if (n != 13) begin
      failures++;
      $display("FAIL loss_resequence_cycles: got %0d expected 13", n);
    end
    checks++;
    if (lock_lost !== 1'b1) begin
      failures++;
      $display("FAIL loss_sticky: got %b expected 1", lock_lost);
    end
    checks++;
    if (lock_loss_cnt !== c_EXP_LOSS) begin
      failures++;
      $display("FAIL loss_cnt: got %0d expected %0d", lock_loss_cnt, c_EXP_LOSS);
    end
  endtask

  // Continues from RUN with lock_lost already set by the previous scenario.
  task automatic test_async_reset_stable();
    int n;
    pll_locked = 1'b0;
    repeat (3) tick();
    pll_locked = 1'b1;
    repeat (5) tick();
    checks++;
    if ({pll_rst, sys_rst, ready} !== 3'b010) begin
      failures++;
      $display("FAIL async_pre_stable: got %b expected 010", {pll_rst, sys_rst, ready});
    end
    tick();
    tick();
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({pll_rst, sys_rst, ready, fault, lock_lost} !== 5'b11000) begin
      failures++;
      $display("FAIL async_flags: got %b expected 11000", {pll_rst, sys_rst, ready, fault, lock_lost});
    end
    checks++;
    if ({retry_cnt, lock_loss_cnt} !== 20'd0) begin
      failures++;
      $display("FAIL async_counts: got %0d/%0d expected 0/0", retry_cnt, lock_loss_cnt);
    end
    tick();
    rst = 1'b0;
    n = 0;
    while (pll_rst === 1'b1 && n < 50) begin tick(); n++; end
    checks++;
    if (n != RST_CYCLES) begin
      failures++;
      $display("FAIL async_release_pll_rst_len: got %0d expected %0d", n, RST_CYCLES);
    end
  endtask

  initial begin
    rst        = 1'b1;
    pll_locked = 1'b0;
    restart    = 1'b0;
    test_reset();
    test_bringup();
    test_chatter();
    test_timeout();
    test_restart_ignored();
    test_loss_in_run();
    test_async_reset_stable();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
